// File: rtl/alu_stage.sv
// ALU stage of the 8-bit bus computer.
// Single-cycle ops plus an iterative shift-add MUL.
module alu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_value,
  input  logic [WIDTH-1:0] b_value,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             n_out,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  // Next-state: MUL iterates WIDTH cycles, all else one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (op == 3'b111) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: state_d = S_IDLE;
      S_MUL: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle operation results from latched operands
  always_comb begin
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
    alu_r = '0;
    alu_c = 1'b0;
    unique case (op_q)
      3'b000: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
      end
      3'b001: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
      end
      3'b010: alu_r = a_q & b_q;
      3'b011: alu_r = a_q | b_q;
      3'b100: alu_r = a_q ^ b_q;
      3'b101: begin
        alu_r = {a_q[WIDTH-2:0], 1'b0};
        alu_c = a_q[WIDTH-1];
      end
      3'b110: begin
        alu_r = {1'b0, a_q[WIDTH-1:1]};
        alu_c = a_q[0];
      end
      3'b111: begin
        alu_r = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  // Operand capture, shift-add steps and result write
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_value;
          b_d      = b_value;
          op_d     = op;
          mcand_d  = {{WIDTH{1'b0}}, a_value};
          mplier_d = b_value;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      S_EXEC: begin
        result_d = alu_r;
        carry_d  = alu_c;
        zero_d   = (alu_r == '0);
        done_d   = 1'b1;
      end
      S_MUL: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = prod_d[WIDTH-1:0];
          carry_d  = |prod_d[2*WIDTH-1:WIDTH];
          zero_d   = (prod_d[WIDTH-1:0] == '0);
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status and bus outputs
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = done_q;
    carry_flag = carry_q;
    zero_flag  = zero_q;
    bus_out    = n_out ? '0 : result_q;
    bus_drive  = ~n_out;
  end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage.
// Directed cases plus random ops against an arithmetic model.
module tb_alu_stage;

  logic       clk;
  logic       rst;
  logic [7:0] a_value;
  logic [7:0] b_value;
  logic [2:0] op;
  logic       start;
  logic       n_out;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic       busy;
  logic       done;
  logic       carry_flag;
  logic       zero_flag;

  int n_checks = 0;
  int n_fail   = 0;

  alu_stage #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_value    (a_value),
    .b_value    (b_value),
    .op         (op),
    .start      (start),
    .n_out      (n_out),
    .bus_out    (bus_out),
    .bus_drive  (bus_drive),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(
    input int o, input int a, input int b,
    output int r, output bit c);
    int t;
    c = 1'b0;
    case (o)
      0: begin t = a + b; r = t % 256; c = (t > 255); end
      1: begin r = (a - b + 256) % 256; c = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; c = (a >= 128); end
      6: begin r = a / 2; c = (a % 2 == 1); end
      default: begin
        t = a * b; r = t % 256; c = (t >= 256);
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(
    input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
    output int lat, output int bcnt,
    output logic [7:0] r, output logic c, output logic z);
    op = o; a_value = a; b_value = b; start = 1'b1;
    lat = 0; bcnt = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    r = bus_out; c = carry_flag; z = zero_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_out = 1'b0;
    op = '0; a_value = '0; b_value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (bus_out !== 8'h00 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: res=%h c=%b z=%b want 00 0 0",
               bus_out, carry_flag, zero_flag);
    end
  endtask

  task automatic test_add();
    int lat, bc; logic [7:0] r; logic c, z;
    run_op(3'b000, 8'hF0, 8'h20, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h10 || c !== 1'b1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL add: got %h c%b z%b want 10 c1 z0", r, c, z);
    end
    n_checks++;
    if (lat != 2 || bc != 1) begin
      n_fail++;
      $display("FAIL add_timing: lat=%0d busy=%0d want 2 1", lat, bc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_sub();
    int lat, bc; logic [7:0] r; logic c, z;
    run_op(3'b001, 8'h05, 8'h05, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_eq: got %h c%b z%b want 00 c1 z1", r, c, z);
    end
    run_op(3'b001, 8'h03, 8'h05, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'hFE || c !== 1'b0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h c%b z%b want FE c0 z0", r, c, z);
    end
  endtask

  task automatic test_mul();
    int lat, bc; logic [7:0] r; logic c, z;
    run_op(3'b111, 8'h0D, 8'h0B, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h8F || c !== 1'b0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL mul: got %h c%b z%b want 8F c0 z0", r, c, z);
    end
    n_checks++;
    if (lat != 9 || bc != 8) begin
      n_fail++;
      $display("FAIL mul_timing: lat=%0d busy=%0d want 9 8", lat, bc);
    end
    run_op(3'b111, 8'h20, 8'h10, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ovf: got %h c%b z%b want 00 c1 z1", r, c, z);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    logic [7:0] held;
    held = bus_out;
    op = 3'b111; a_value = 8'h0D; b_value = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) begin
        op = 3'b000; a_value = 8'h01; b_value = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (lat == 5) begin
        n_checks++;
        if (bus_out !== held) begin
          n_fail++;
          $display("FAIL mul_hold: res=%h want %h", bus_out, held);
        end
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (bus_out !== 8'h8F || lat != 9) begin
      n_fail++;
      $display("FAIL ignore_start: res=%h lat=%0d want 8F 9", bus_out, lat);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL no_extra_done: activity=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc; logic [7:0] r; logic c, z;
    run_op(3'b000, 8'hF0, 8'h20, lat, bc, r, c, z);
    op = 3'b111; a_value = 8'hFF; b_value = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus_out !== 8'h00 ||
        carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_mul: b%b d%b r%h c%b z%b want all 0",
               busy, done, bus_out, carry_flag, zero_flag);
    end
    run_op(3'b000, 8'h01, 8'h01, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h02 || c !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL add_after_rst: got %h c%b lat%0d want 02 c0 2", r, c, lat);
    end
  endtask

  task automatic test_bus();
    int lat, bc; logic [7:0] r; logic c, z;
    run_op(3'b100, 8'h5A, 8'h00, lat, bc, r, c, z);
    @(negedge clk);
    n_out = 1'b0;
    #1;
    n_checks++;
    if (bus_out !== 8'h5A || bus_drive !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_on: out=%h drv=%b want 5A 1", bus_out, bus_drive);
    end
    n_out = 1'b1;
    #1;
    n_checks++;
    if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_off: out=%h drv=%b want 00 0", bus_out, bus_drive);
    end
    n_out = 1'b0;
    @(negedge clk);
    run_op(3'b101, 8'h81, 8'h00, lat, bc, r, c, z);
    n_checks++;
    if (r !== 8'h02 || c !== 1'b1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL shl: got %h c%b z%b want 02 c1 z0", r, c, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, er, elat;
    bit ec;
    logic [7:0] r, a, b; logic c, z;
    logic [2:0] o;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i % 10 == 0) b = a;
      model(int'(o), int'(a), int'(b), er, ec);
      elat = (o == 3'b111) ? 9 : 2;
      run_op(o, a, b, lat, bc, r, c, z);
      n_checks++;
      if (r !== 8'(er) || c !== ec || z !== (er == 0) || lat != elat) begin
        n_fail++;
        $display("FAIL rand op%0d a=%h b=%h: r%h c%b z%b lat%0d want r%h c%b z%b lat%0d",
                 o, a, b, r, c, z, lat, 8'(er), ec, (er == 0), elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_start_while_busy();
    test_reset_mid_mul();
    test_bus();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
